// File: rtl/alu_share_arbiter_if.sv
// Bundle of request, ALU-side and response signals for alu_share_arbiter.
// The arbiter connects through the slave modport; the environment
// (requesters, ALU and response consumer) uses the master modport.
interface alu_share_arbiter_if #(
  parameter int DW = 32,
  parameter int CW = 4
);
  // requester 0
  logic          req0_valid;
  logic          req0_ready;
  logic [DW-1:0] req0_src1;
  logic [DW-1:0] req0_src2;
  logic [CW-1:0] req0_ctrl;
  // requester 1
  logic          req1_valid;
  logic          req1_ready;
  logic [DW-1:0] req1_src1;
  logic [DW-1:0] req1_src2;
  logic [CW-1:0] req1_ctrl;
  // shared combinational ALU
  logic [DW-1:0] alu_src1;
  logic [DW-1:0] alu_src2;
  logic [CW-1:0] alu_ctrl;
  logic [DW-1:0] alu_result;
  logic          alu_zero;
  logic          alu_cout;
  logic          alu_overflow;
  // response channel
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_id;
  logic [DW-1:0] rsp_result;
  logic          rsp_zero;
  logic          rsp_cout;
  logic          rsp_overflow;

  modport slave (
    input  req0_valid, req0_src1, req0_src2, req0_ctrl,
    output req0_ready,
    input  req1_valid, req1_src1, req1_src2, req1_ctrl,
    output req1_ready,
    output alu_src1, alu_src2, alu_ctrl,
    input  alu_result, alu_zero, alu_cout, alu_overflow,
    output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_cout, rsp_overflow,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_src1, req0_src2, req0_ctrl,
    input  req0_ready,
    output req1_valid, req1_src1, req1_src2, req1_ctrl,
    input  req1_ready,
    input  alu_src1, alu_src2, alu_ctrl,
    output alu_result, alu_zero, alu_cout, alu_overflow,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_cout, rsp_overflow,
    output rsp_ready
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Operands are registered toward the ALU, the result and flags are
// registered into a single response channel tagged with the owner id.
// Sequence per operation: IDLE (grant) -> EXEC (ALU evaluates) -> RESP.
module alu_share_arbiter #(
  parameter int DW = 32,
  parameter int CW = 4
) (
  input  logic               clk_i,
  input  logic               rst_n,
  alu_share_arbiter_if.slave bus,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state_q,      state_d;
  logic          last_grant_q, last_grant_d;
  logic          grant_id_q,   grant_id_d;
  logic [DW-1:0] op_src1_q,    op_src1_d;
  logic [DW-1:0] op_src2_q,    op_src2_d;
  logic [CW-1:0] op_ctrl_q,    op_ctrl_d;
  logic          rsp_valid_q,  rsp_valid_d;
  logic          rsp_id_q,     rsp_id_d;
  logic [DW-1:0] rsp_result_q, rsp_result_d;
  logic          rsp_zero_q,   rsp_zero_d;
  logic          rsp_cout_q,   rsp_cout_d;
  logic          rsp_ovf_q,    rsp_ovf_d;
  logic          req0_ready;
  logic          req1_ready;

  // Next-state, grant and capture decisions
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    op_src1_d    = op_src1_q;
    op_src2_d    = op_src2_q;
    op_ctrl_d    = op_ctrl_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_cout_d   = rsp_cout_q;
    rsp_ovf_d    = rsp_ovf_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;

    case (state_q)
      IDLE: begin
        // On a tie the requester that did not win last time is served.
        if (bus.req0_valid && (!bus.req1_valid || last_grant_q)) begin
          req0_ready   = 1'b1;
          op_src1_d    = bus.req0_src1;
          op_src2_d    = bus.req0_src2;
          op_ctrl_d    = bus.req0_ctrl;
          grant_id_d   = 1'b0;
          last_grant_d = 1'b0;
          state_d      = EXEC;
        end else if (bus.req1_valid) begin
          req1_ready   = 1'b1;
          op_src1_d    = bus.req1_src1;
          op_src2_d    = bus.req1_src2;
          op_ctrl_d    = bus.req1_ctrl;
          grant_id_d   = 1'b1;
          last_grant_d = 1'b1;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_result_d = bus.alu_result;
        rsp_zero_d   = bus.alu_zero;
        rsp_cout_d   = bus.alu_cout;
        rsp_ovf_d    = bus.alu_overflow;
        rsp_id_d     = grant_id_q;
        rsp_valid_d  = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        // The response slot is the only one, so no grant until it drains.
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      op_src1_q    <= '0;
      op_src2_q    <= '0;
      op_ctrl_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_cout_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      op_src1_q    <= op_src1_d;
      op_src2_q    <= op_src2_d;
      op_ctrl_q    <= op_ctrl_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_cout_q   <= rsp_cout_d;
      rsp_ovf_q    <= rsp_ovf_d;
    end
  end

  assign bus.req0_ready   = req0_ready;
  assign bus.req1_ready   = req1_ready;
  assign bus.alu_src1     = op_src1_q;
  assign bus.alu_src2     = op_src2_q;
  assign bus.alu_ctrl     = op_ctrl_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_zero     = rsp_zero_q;
  assign bus.rsp_cout     = rsp_cout_q;
  assign bus.rsp_overflow = rsp_ovf_q;
  assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a simple behavioural ALU
// (0010 add, 0110 subtract) standing in for the shared datapath.
module tb_alu_share_arbiter;

  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   tests  = 0;
  int   failed = 0;

  alu_share_arbiter_if #(.DW(32), .CW(4)) bus ();

  alu_share_arbiter #(.DW(32), .CW(4)) dut (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .busy  (busy)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural ALU: 33-bit sum gives carry, sign rule gives overflow
  logic [32:0] alu_wide;
  always_comb begin
    alu_wide = 33'd0;
    bus.alu_overflow = 1'b0;
    if (bus.alu_ctrl == 4'b0110) begin
      alu_wide = {1'b0, bus.alu_src1} + {1'b0, ~bus.alu_src2} + 33'd1;
      bus.alu_overflow = (bus.alu_src1[31] != bus.alu_src2[31]) &&
                         (alu_wide[31] != bus.alu_src1[31]);
    end else begin
      alu_wide = {1'b0, bus.alu_src1} + {1'b0, bus.alu_src2};
      bus.alu_overflow = (bus.alu_src1[31] == bus.alu_src2[31]) &&
                         (alu_wide[31] != bus.alu_src1[31]);
    end
    bus.alu_result = alu_wide[31:0];
    bus.alu_cout   = alu_wide[32];
    bus.alu_zero   = (alu_wide[31:0] == 32'd0);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!(bus.req0_ready || bus.req1_ready) && n < 20) begin
      step();
      n++;
    end
    check({tag, "_ready_timeout"}, 64'(bus.req0_ready || bus.req1_ready), 64'd1);
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!bus.rsp_valid && n < 20) begin
      step();
      n++;
    end
    check({tag, "_rsp_timeout"}, 64'(bus.rsp_valid), 64'd1);
    $display("[TB] %s rsp id=%0d result=%08h z=%0d c=%0d v=%0d", tag, bus.rsp_id,
             bus.rsp_result, bus.rsp_zero, bus.rsp_cout, bus.rsp_overflow);
  endtask

  initial begin
    bus.req0_valid = 1'b0; bus.req0_src1 = '0; bus.req0_src2 = '0; bus.req0_ctrl = '0;
    bus.req1_valid = 1'b0; bus.req1_src1 = '0; bus.req1_src2 = '0; bus.req1_ctrl = '0;
    bus.rsp_ready  = 1'b0;

    // ---- reset then idle ----
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("idle_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_ready0", 64'(bus.req0_ready), 64'd0);
    check("idle_ready1", 64'(bus.req1_ready), 64'd0);
    check("idle_alu_src1", 64'(bus.alu_src1), 64'd0);
    check("idle_alu_src2", 64'(bus.alu_src2), 64'd0);
    check("idle_alu_ctrl", 64'(bus.alu_ctrl), 64'd0);

    // ---- single op: req0 5+7 ----
    bus.req0_valid = 1'b1; bus.req0_src1 = 32'd5; bus.req0_src2 = 32'd7; bus.req0_ctrl = 4'b0010;
    #1;
    check("single_ready0", 64'(bus.req0_ready), 64'd1);
    check("single_ready1", 64'(bus.req1_ready), 64'd0);
    step();
    bus.req0_valid = 1'b0;
    check("single_exec_ready0", 64'(bus.req0_ready), 64'd0);
    check("single_exec_src1", 64'(bus.alu_src1), 64'd5);
    check("single_exec_src2", 64'(bus.alu_src2), 64'd7);
    check("single_exec_busy", 64'(busy), 64'd1);
    check("single_exec_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    step();
    check("single_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("single_result", 64'(bus.rsp_result), 64'd12);
    check("single_id", 64'(bus.rsp_id), 64'd0);
    check("single_flags", 64'({bus.rsp_zero, bus.rsp_cout, bus.rsp_overflow}), 64'd0);
    $display("[TB] single rsp id=%0d result=%08h", bus.rsp_id, bus.rsp_result);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    check("single_drained", 64'(bus.rsp_valid), 64'd0);
    check("single_idle", 64'(busy), 64'd0);
    check("single_held", 64'(bus.rsp_result), 64'd12);

    // ---- reset during EXEC: req1 9+9 is discarded ----
    bus.req1_valid = 1'b1; bus.req1_src1 = 32'd9; bus.req1_src2 = 32'd9; bus.req1_ctrl = 4'b0010;
    #1;
    check("abort_ready1", 64'(bus.req1_ready), 64'd1);
    step();
    bus.req1_valid = 1'b0;
    check("abort_in_exec", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_rsp_valid_async", 64'(bus.rsp_valid), 64'd0);
    check("abort_busy_async", 64'(busy), 64'd0);
    check("abort_alu_src1", 64'(bus.alu_src1), 64'd0);
    step();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort_no_rsp", 64'(bus.rsp_valid), 64'd0);
    end
    $display("[TB] abort: no response for discarded op");

    // ---- round robin: both continuously valid, grants 0,1,0,1 ----
    bus.req0_valid = 1'b1; bus.req0_src1 = 32'd10; bus.req0_src2 = 32'd10; bus.req0_ctrl = 4'b0110;
    bus.req1_valid = 1'b1; bus.req1_src1 = 32'h7FFF_FFFF; bus.req1_src2 = 32'd1; bus.req1_ctrl = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      #1;
      wait_ready("rr");
      check("rr_grant0", 64'(bus.req0_ready), 64'((k % 2) == 0));
      check("rr_grant1", 64'(bus.req1_ready), 64'((k % 2) == 1));
      step();
      wait_rsp("rr");
      if ((k % 2) == 0) begin
        check("rr0_id", 64'(bus.rsp_id), 64'd0);
        check("rr0_result", 64'(bus.rsp_result), 64'd0);
        check("rr0_zero", 64'(bus.rsp_zero), 64'd1);
      end else begin
        check("rr1_id", 64'(bus.rsp_id), 64'd1);
        check("rr1_result", 64'(bus.rsp_result), 64'h8000_0000);
        check("rr1_overflow", 64'(bus.rsp_overflow), 64'd1);
        check("rr1_zero", 64'(bus.rsp_zero), 64'd0);
      end
      step();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b0;
    step();

    // ---- backpressure: req0 3+4 held, req1 1+1 pending ----
    bus.req0_valid = 1'b1; bus.req0_src1 = 32'd3; bus.req0_src2 = 32'd4; bus.req0_ctrl = 4'b0010;
    bus.req1_valid = 1'b1; bus.req1_src1 = 32'd1; bus.req1_src2 = 32'd1; bus.req1_ctrl = 4'b0010;
    #1;
    check("bp_grant0", 64'(bus.req0_ready), 64'd1);
    step();
    bus.req0_valid = 1'b0;
    step();
    check("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("bp_result", 64'(bus.rsp_result), 64'd7);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_valid", 64'(bus.rsp_valid), 64'd1);
      check("bp_hold_result", 64'(bus.rsp_result), 64'd7);
      check("bp_hold_id", 64'(bus.rsp_id), 64'd0);
      check("bp_no_ready", 64'({bus.req0_ready, bus.req1_ready}), 64'd0);
      check("bp_busy", 64'(busy), 64'd1);
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_no_grant_in_resp", 64'(bus.req1_ready), 64'd0);
    step();
    check("bp_drained", 64'(bus.rsp_valid), 64'd0);
    check("bp_idle", 64'(busy), 64'd0);
    check("bp_pending_grant", 64'(bus.req1_ready), 64'd1);
    check("bp_result_held", 64'(bus.rsp_result), 64'd7);
    $display("[TB] backpressure rsp id=0 result=%08h released", bus.rsp_result);
    step();
    bus.req1_valid = 1'b0;
    step();
    check("bp_second_result", 64'(bus.rsp_result), 64'd2);
    check("bp_second_id", 64'(bus.rsp_id), 64'd1);
    step();

    // ---- carry path: req1 FFFFFFFF+1 ----
    bus.req1_valid = 1'b1; bus.req1_src1 = 32'hFFFF_FFFF; bus.req1_src2 = 32'd1; bus.req1_ctrl = 4'b0010;
    #1;
    wait_ready("carry");
    check("carry_grant1", 64'(bus.req1_ready), 64'd1);
    step();
    bus.req1_valid = 1'b0;
    wait_rsp("carry");
    check("carry_result", 64'(bus.rsp_result), 64'd0);
    check("carry_cout", 64'(bus.rsp_cout), 64'd1);
    check("carry_zero", 64'(bus.rsp_zero), 64'd1);
    check("carry_overflow", 64'(bus.rsp_overflow), 64'd0);
    check("carry_id", 64'(bus.rsp_id), 64'd1);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational 32-bit ALU (rst_n, src1, src2, 4-bit ALU_control, result, zero, cout, overflow) between two requesters, e.g. the execute stage and a branch/address unit.
- Round-robin grant, valid/ready handshake on the request side, registered operands toward the ALU, registered result/flags back on a single response channel tagged with requester ID.

Parameters:
- DW, 32, operand/result width.
- CW, 4, ALU control width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_src1  in  DW  requester 0 operand 1.
- req0_src2  in  DW  requester 0 operand 2.
- req0_ctrl  in  CW  requester 0 ALU control code.
- req1_valid, req1_ready, req1_src1, req1_src2, req1_ctrl: same directions and widths as requester 0.
- alu_src1  out  DW  to ALU src1.
- alu_src2  out  DW  to ALU src2.
- alu_ctrl  out  CW  to ALU ALU_control.
- alu_result  in  DW  from ALU result.
- alu_zero  in  1  from ALU zero.
- alu_cout  in  1  from ALU cout.
- alu_overflow  in  1  from ALU overflow.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester that owns the response.
- rsp_result  out  DW  captured result.
- rsp_zero  out  1  captured zero flag.
- rsp_cout  out  1  captured carry-out flag.
- rsp_overflow  out  1  captured overflow flag.
- busy  out  1  high in EXEC or RESP.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - All operand, ctrl and response registers clear to 0; rsp_valid=0; busy=0.
  - last_grant=1, so requester 0 wins the first tie.
  - Any in-flight operation is discarded; no response is produced for it.
- State machine IDLE -> EXEC -> RESP -> IDLE:
  - IDLE:
    - If neither valid: stay.
    - If exactly one valid: grant it.
    - If both valid: grant the requester != last_grant.
    - Grant is combinational in the same cycle: reqN_ready=1 for the granted requester only; its src1/src2/ctrl load into the operand registers; grant_id and last_grant update. Next state is EXEC.
    - reqN_ready is 0 in every other state and for the non-granted requester.
  - EXEC:
    - alu_src1, alu_src2 and alu_ctrl come from the operand registers; they are always register outputs, never combinational from req inputs.
    - At cycle end, alu_result and the three flags load into the rsp registers; rsp_id=grant_id; rsp_valid=1. Next state is RESP.
  - RESP:
    - Response outputs are held stable while rsp_valid=1 and rsp_ready=0.
    - On rsp_ready=1: rsp_valid clears next edge and state goes to IDLE. No new grant happens in this cycle.
- Latency: request accepted at edge T gives rsp_valid high after edge T+2. Throughput is one operation per 3 cycles minimum.
- Operand registers hold their last value outside EXEC (ALU inputs stay quiet). Response registers hold their last value after acceptance.
- Data is passed unmodified; the block does not interpret ctrl codes or flags.
- busy = (state != IDLE).
- Requests arriving while busy wait; a requester's fields must stay stable until its ready pulse.
- Starvation-free: with both requesters continuously valid, grants alternate 0,1,0,1...
- Reset asserted in EXEC or RESP: capture is aborted; rsp_valid=0 immediately, asynchronously.

Test Plan:
- Reset then idle: rst_n low 3 cycles, then high with no valids -> rsp_valid=0, busy=0, all ready=0, alu_* = 0.
- Single op: req0 add (ctrl 4'b0010, 5+7) -> req0_ready pulses 1 cycle; alu_src1=5, alu_src2=7 in EXEC; rsp_valid 2 cycles later with rsp_result=12, rsp_id=0, zero=0, cout=0, overflow=0.
- Tie and round-robin: both valid continuously, rsp_ready=1, req0 does 10-10 and req1 does 0x7FFFFFFF+1 -> grants ordered 0,1,0,1:
  - Requester 0 responses: result 0, zero=1.
  - Requester 1 responses: result 0x80000000, overflow=1, rsp_id=1.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> all rsp_* stable, no req_ready pulses, busy=1; rsp_ready=1 gives IDLE next cycle, then the pending request is granted.
- Reset mid-operation: rst_n low during EXEC -> rsp_valid never rises for that operation. After release, simultaneous req0/req1 grant req0 first (last_grant=1).
- Carry path: req1 0xFFFFFFFF+1 add -> rsp_result=0, rsp_cout=1, rsp_zero=1, rsp_overflow=0, rsp_id=1.
